interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Upstream feeder of the next-PC select mux: collects external interrupt requests, arbitrates by
//  fixed priority, raises a one-cycle INT pulse that forces the mux onto the handler vector, and
//  owns the EPC/cause registers. Sequences ERET so fetch returns to the saved EPC. Sits beside
//  the PC register in the fetch stage.
// PARAMETERS
//  NUM_IRQ      4             number of request lines (1..8)
//  VECTOR_BASE  32'h0000_0080 handler base address; vector = VECTOR_BASE + (cause << 3)
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  rst         in   1        synchronous, active-high reset
//  irq_in      in   NUM_IRQ  level requests, already synchronous to clk
//  mask_we     in   1        write enable for mask register
//  mask_wdata  in   NUM_IRQ  new mask (1 = enabled)
//  pc_current  in   32       PC of oldest uncommitted instruction (restart point)
//  stall_in    in   1        pipeline cannot accept redirect this cycle (stall/branch in flight)
//  eret        in   1        ERET instruction in EX
//  int_out     out  1        one-cycle pulse to PC mux INT input
//  vector_out  out  32       handler address driven to PC mux vector input
//  eret_out    out  1        one-cycle pulse: PC mux must select epc_out
//  epc_out     out  32       saved restart PC
//  cause_out   out  3        index of serviced request
//  busy        out  1        high from TAKE through RETURN
// BEHAVIOUR
//  Reset: state=IDLE; pending, irq_q, epc, cause = 0; mask = all-ones; all outputs 0;
//   vector_out = VECTOR_BASE.
//  Edge detect: irq_q <= irq_in; rise = irq_in & ~irq_q. pending <= (pending & ~clr) | rise;
//   set wins over clear on the same bit in the same cycle.
//  Eligible = pending & mask; winner = lowest set index (bit 0 highest priority).
//  FSM (registered state; outputs decoded from state):
//   IDLE    : |eligible && !stall_in -> TAKE; latch epc<=pc_current, cause<=winner,
//             clear pending[winner]. stall_in high -> hold, pending retained.
//   TAKE    : int_out=1 (exactly 1 cycle), busy=1 -> SERVICE unconditionally.
//   SERVICE : busy=1; new requests stay pending (no nesting); eret -> RETURN.
//   RETURN  : eret_out=1 (exactly 1 cycle), busy=1 -> IDLE. No take in this cycle.
//  eret while IDLE or TAKE: ignored, no pulse.
//  Latency: rising irq at edge N -> pending at N+1 -> TAKE at N+2 (int_out high cycle N+2)
//   when unmasked and no stall.
//  vector_out = VECTOR_BASE + {cause, 3'b000}, 32-bit wrap; epc_out/cause_out stable SERVICE->next take.
//  Mask write: takes effect next cycle; take decision in the write cycle uses old mask.
//   Masked pending bits are retained and fire once unmasked.
//  rst mid-operation (any state): return to reset values next edge; int_out/eret_out drop at once.
// STRUCTURE
//  Shared package: state encoding (IDLE/TAKE/SERVICE/RETURN), VECTOR_BASE default,
//   CAUSE_W=3, vector shift constant (3).
//  One sub-module: irq_priority_encoder (combinational NUM_IRQ -> {valid, index}).
//  Top holds edge-detect, pending, mask, EPC/cause registers and FSM.
// TESTING
//  1 rst, irq_in=4'b0100 at cycle 2, pc_current=32'h0000_0040 -> int_out pulse cycle 4,
//    cause_out=2, vector_out=32'h0000_0090, epc_out=32'h0000_0040.
//  2 irq_in=4'b1010 same edge -> cause 1 serviced first; after eret, bit 3 taken, cause=3,
//    vector=32'h0000_0098.
//  3 pending bit 0 with stall_in=1 for 5 cycles -> no int_out; first cycle stall_in=0 -> TAKE next edge.
//  4 mask_wdata=4'b1110, irq bit 0 rises -> no take; rewrite mask=4'b1111 -> take with cause 0.
//  5 In SERVICE, eret=1 -> eret_out high 1 cycle, epc_out unchanged; eret in IDLE -> no eret_out.
//  6 rst asserted during SERVICE with bit 2 pending -> next cycle busy=0, pending=0, epc_out=0, no int_out.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding, default vector base,
// cause width and vector spacing. Pure declarations, no latency and no backpressure.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } irq_state_t;

  localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0080;
  localparam int          CAUSE_W         = 3;
  localparam int          VEC_SHIFT       = 3;

  // Each handler slot is 8 bytes; 32-bit wrap is intended.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [CAUSE_W-1:0] cause);
    return base + (32'(cause) << VEC_SHIFT);
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bundle between the fetch stage and the interrupt controller. The master side drives requests
// and pipeline status; the slave side (controller) returns the redirect pulses and saved state.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 4
);
  import interrupt_controller_pkg::*;

  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [31:0]        pc_current;
  logic               stall_in;
  logic               eret;
  logic               int_out;
  logic [31:0]        vector_out;
  logic               eret_out;
  logic [31:0]        epc_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               busy;

  modport master (
    output irq_in, mask_we, mask_wdata, pc_current, stall_in, eret,
    input  int_out, vector_out, eret_out, epc_out, cause_out, busy
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, pc_current, stall_in, eret,
    output int_out, vector_out, eret_out, epc_out, cause_out, busy
  );

endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// Fixed-priority encoder, bit 0 highest priority. Purely combinational, zero latency;
// no backpressure, the caller decides whether the result is consumed.
module irq_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [CAUSE_W-1:0] o_index
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_index = CAUSE_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detected IRQs -> pending/mask -> priority take; INT pulse two edges after a rise, ERET pulse on return.
// A stalled pipeline holds the take with requests kept pending; no nesting while a handler is active.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] VECTOR_BASE = VECTOR_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  interrupt_controller_if.slave bus
);

  irq_state_t         r_state;
  irq_state_t         w_next_state;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [31:0]        r_epc;
  logic [CAUSE_W-1:0] r_cause;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_win_vld;
  logic [CAUSE_W-1:0] w_win_idx;
  logic               w_take;

  assign w_rise     = bus.irq_in & ~r_irq_q;
  assign w_eligible = r_pending & r_mask;
  assign w_clr      = w_take ? (NUM_IRQ'(1) << w_win_idx) : '0;

  irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req   (w_eligible),
    .o_valid (w_win_vld),
    .o_index (w_win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld && !bus.stall_in) begin
          w_take       = 1'b1;
          w_next_state = ST_TAKE;
        end
      end
      ST_TAKE:    w_next_state = ST_SERVICE;
      ST_SERVICE: if (bus.eret) w_next_state = ST_RETURN;
      ST_RETURN:  w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // A new rise on the bit being taken this cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= '1;
      r_epc     <= '0;
      r_cause   <= '0;
    end else begin
      r_irq_q   <= bus.irq_in;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      if (w_take) begin
        r_epc   <= bus.pc_current;
        r_cause <= w_win_idx;
      end
    end
  end

  // Pulses are gated by rst so a reset cancels a redirect in the same cycle.
  assign bus.int_out    = (r_state == ST_TAKE) && !rst;
  assign bus.eret_out   = (r_state == ST_RETURN) && !rst;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.vector_out = vec_addr(VECTOR_BASE, r_cause);
  assign bus.epc_out    = r_epc;
  assign bus.cause_out  = r_cause;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic against a flag-based reference model of the controller.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  interrupt_controller_if #(.NUM_IRQ(4)) bus();

  interrupt_controller #(.NUM_IRQ(4), .VECTOR_BASE(32'h0000_0080)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: handler phase flags, pending set as plain bits.
  bit [3:0]    m_prev, m_pend, m_mask;
  logic [31:0] m_epc;
  int          m_cause;
  bit          m_int, m_serv, m_ret;

  task automatic model_edge();
    bit [3:0] elig, low;
    bit       take, was_serv;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_mask = 4'hF; m_epc = '0; m_cause = 0;
      m_int = 0; m_serv = 0; m_ret = 0;
    end else begin
      elig = m_pend & m_mask;
      take = !(m_int || m_serv || m_ret) && (elig != 0) && !bus.stall_in;
      low  = '0;
      if (take) begin
        low     = elig & (~elig + 4'd1);
        m_cause = $clog2(low);
        m_epc   = bus.pc_current;
      end
      m_pend = (m_pend & ~low) | (bus.irq_in & ~m_prev);
      m_prev = bus.irq_in;
      if (bus.mask_we) m_mask = bus.mask_wdata;
      was_serv = m_serv;
      m_ret  = was_serv && bus.eret;
      m_serv = m_int || (was_serv && !bus.eret);
      m_int  = take;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic finish_handler();
    bus.eret = 1'b1; tick();
    bus.eret = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_tests++; if (bus.int_out !== 1'b0 || bus.eret_out !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: int=%b eret=%b busy=%b expected 0 0 0", bus.int_out, bus.eret_out, bus.busy); end
    n_tests++; if (bus.vector_out !== 32'h80 || bus.epc_out !== 32'h0 || bus.cause_out !== 3'd0) begin
      n_fail++; $display("FAIL reset_regs: vec=%h epc=%h cause=%0d expected 80 0 0", bus.vector_out, bus.epc_out, bus.cause_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.irq_in = 4'b0100; bus.pc_current = 32'h40; tick();
    n_tests++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL basic_early: int=%b expected 0", bus.int_out); end
    tick();
    n_tests++; if (bus.int_out !== 1'b1 || bus.cause_out !== 3'd2) begin
      n_fail++; $display("FAIL basic_take: int=%b cause=%0d expected 1 2", bus.int_out, bus.cause_out); end
    n_tests++; if (bus.vector_out !== 32'h90 || bus.epc_out !== 32'h40) begin
      n_fail++; $display("FAIL basic_vec: vec=%h epc=%h expected 90 40", bus.vector_out, bus.epc_out); end
    tick();
    n_tests++; if (bus.int_out !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_pulse: int=%b busy=%b expected 0 1", bus.int_out, bus.busy); end
    finish_handler();
    bus.irq_in = 4'b0000; tick();
  endtask

  task automatic test_priority();
    bus.irq_in = 4'b1010; tick(); tick();
    n_tests++; if (bus.int_out !== 1'b1 || bus.cause_out !== 3'd1 || bus.vector_out !== 32'h88) begin
      n_fail++; $display("FAIL prio_first: int=%b cause=%0d vec=%h expected 1 1 88", bus.int_out, bus.cause_out, bus.vector_out); end
    tick(); finish_handler(); tick();
    n_tests++; if (bus.int_out !== 1'b1 || bus.cause_out !== 3'd3 || bus.vector_out !== 32'h98) begin
      n_fail++; $display("FAIL prio_second: int=%b cause=%0d vec=%h expected 1 3 98", bus.int_out, bus.cause_out, bus.vector_out); end
    tick(); finish_handler();
    bus.irq_in = 4'b0000; tick();
  endtask

  task automatic test_stall();
    int seen = 0;
    bus.stall_in = 1'b1; bus.irq_in = 4'b0001; tick();
    for (int i = 0; i < 5; i++) begin tick(); seen += int'(bus.int_out); end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL stall_hold: int pulses=%0d expected 0", seen); end
    bus.stall_in = 1'b0; tick();
    n_tests++; if (bus.int_out !== 1'b1 || bus.cause_out !== 3'd0) begin
      n_fail++; $display("FAIL stall_release: int=%b cause=%0d expected 1 0", bus.int_out, bus.cause_out); end
    tick(); finish_handler();
    bus.irq_in = 4'b0000; tick();
  endtask

  task automatic test_mask();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1110; tick();
    bus.mask_we = 1'b0; bus.irq_in = 4'b0001; tick(); tick(); tick();
    n_tests++; if (bus.int_out !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mask_block: int=%b busy=%b expected 0 0", bus.int_out, bus.busy); end
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111; tick();
    bus.mask_we = 1'b0;
    n_tests++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL mask_old: int=%b expected 0", bus.int_out); end
    tick();
    n_tests++; if (bus.int_out !== 1'b1 || bus.cause_out !== 3'd0) begin
      n_fail++; $display("FAIL mask_release: int=%b cause=%0d expected 1 0", bus.int_out, bus.cause_out); end
    tick(); finish_handler();
    bus.irq_in = 4'b0000; tick();
  endtask

  task automatic test_eret();
    bus.eret = 1'b1; tick(); tick();
    n_tests++; if (bus.eret_out !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL eret_idle: eret_out=%b busy=%b expected 0 0", bus.eret_out, bus.busy); end
    bus.eret = 1'b0; bus.irq_in = 4'b0100; bus.pc_current = 32'h0000_1234; tick(); tick();
    bus.pc_current = 32'h0000_5678; bus.eret = 1'b1; tick();
    n_tests++; if (bus.eret_out !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL eret_take: eret_out=%b busy=%b expected 0 1", bus.eret_out, bus.busy); end
    tick();
    n_tests++; if (bus.eret_out !== 1'b1 || bus.epc_out !== 32'h0000_1234) begin
      n_fail++; $display("FAIL eret_pulse: eret_out=%b epc=%h expected 1 00001234", bus.eret_out, bus.epc_out); end
    bus.eret = 1'b0; tick();
    n_tests++; if (bus.eret_out !== 1'b0 || bus.busy !== 1'b0 || bus.epc_out !== 32'h0000_1234) begin
      n_fail++; $display("FAIL eret_done: eret_out=%b busy=%b epc=%h expected 0 0 00001234", bus.eret_out, bus.busy, bus.epc_out); end
    bus.irq_in = 4'b0000; tick();
  endtask

  task automatic test_rst_mid();
    int seen = 0;
    bus.irq_in = 4'b0100; tick(); tick(); tick();
    bus.irq_in = 4'b0000; tick();
    bus.irq_in = 4'b0100; tick();
    rst = 1'b1; bus.irq_in = 4'b0000; tick();
    rst = 1'b0;
    n_tests++; if (bus.busy !== 1'b0 || bus.epc_out !== 32'h0 || bus.int_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_service: busy=%b epc=%h int=%b expected 0 0 0", bus.busy, bus.epc_out, bus.int_out); end
    for (int i = 0; i < 4; i++) begin tick(); seen += int'(bus.int_out); end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_pending: int pulses=%0d expected 0", seen); end
    bus.irq_in = 4'b0001; tick(); tick();
    rst = 1'b1; #1;
    n_tests++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL rst_drop: int=%b expected 0", bus.int_out); end
    bus.irq_in = 4'b0000; tick();
    rst = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.irq_in = 4'($urandom);
      bus.mask_we    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = 4'($urandom);
      bus.stall_in   = ($urandom_range(0, 3) == 0);
      bus.eret       = ($urandom_range(0, 4) == 0);
      bus.pc_current = $urandom;
      rst            = ($urandom_range(0, 99) == 0);
      tick();
      n_tests++; if (bus.int_out !== m_int || bus.eret_out !== m_ret || bus.busy !== (m_int || m_serv || m_ret)) begin
        n_fail++; $display("FAIL rand_ctl c=%0d: int=%b eret=%b busy=%b expected %b %b %b", c, bus.int_out, bus.eret_out,
                           bus.busy, m_int, m_ret, m_int || m_serv || m_ret); end
      n_tests++; if (bus.cause_out !== 3'(m_cause) || bus.epc_out !== m_epc || bus.vector_out !== 32'h80 + 32'(m_cause * 8)) begin
        n_fail++; $display("FAIL rand_regs c=%0d: cause=%0d epc=%h vec=%h expected %0d %h %h", c, bus.cause_out, bus.epc_out,
                           bus.vector_out, m_cause, m_epc, 32'h80 + 32'(m_cause * 8)); end
    end
    rst = 1'b0; bus.eret = 1'b0; bus.stall_in = 1'b0; bus.mask_we = 1'b0;
  endtask

  initial begin
    bus.irq_in = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.pc_current = '0;
    bus.stall_in = 1'b0; bus.eret = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_priority();
    test_stall();
    test_mask();
    test_eret();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
